// File: rtl/mem_copy_ctrl.sv
// Block-copy sequencer between two fakeram45_64x7 macros joined by an external register pipeline.
// Source reads are tracked through a delay line so each destination write meets its data.
module mem_copy_ctrl #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 7,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] wmask,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              src_ce,
  output logic              src_we,
  output logic [ADDR_W-1:0] src_addr,
  output logic              dst_ce,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_wmask
);

  localparam int unsigned Depth   = RD_LAT + PIPE_DEPTH;
  // The registered dst strobes form the last stage, so the line itself is one shorter.
  localparam int unsigned LineLen = Depth - 1;
  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]     len_q, len_d, len_clamped, cnt_next;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic                abort_flag_q, abort_flag_d;
  logic                busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic                src_ce_q, src_ce_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic                dst_ce_q, dst_ce_d;
  logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;
  logic [DATA_W-1:0]   dst_wmask_q, dst_wmask_d;
  logic [LineLen-1:0]  line_vld_q;
  logic [ADDR_W-1:0]   line_addr_q [LineLen];
  logic                line_empty;

  assign len_clamped = (len > MaxLen) ? MaxLen : len;
  assign cnt_next    = {1'b0, cnt_q} + (ADDR_W + 1)'(1);
  assign line_empty  = ~|line_vld_q;

  always_comb begin
    state_d      = state_q;
    dst_base_d   = dst_base_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    mask_d       = mask_q;
    abort_flag_d = abort_flag_q;
    src_ce_d     = 1'b0;
    src_addr_d   = src_addr_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_addr_d   = src_base;
          dst_base_d   = dst_base;
          len_d        = len_clamped;
          mask_d       = wmask;
          abort_flag_d = 1'b0;
          cnt_d        = '0;
          if (len_clamped == '0) begin
            state_d = StDone;
          end else begin
            state_d  = StRead;
            src_ce_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (abort) begin
          abort_flag_d = 1'b1;
          state_d      = StDrain;
        end else if (cnt_next == len_q) begin
          state_d = StDrain;
        end else begin
          src_ce_d   = 1'b1;
          src_addr_d = src_addr_q + ADDR_W'(1);
          cnt_d      = cnt_next[ADDR_W-1:0];
        end
      end
      StDrain: begin
        // Last write is in the output stage when the line empties; done lands right after it.
        if (line_empty) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    aborted_d   = done_d & abort_flag_d;
    dst_ce_d    = line_vld_q[LineLen-1];
    dst_addr_d  = dst_ce_d ? line_addr_q[LineLen-1] : '0;
    dst_wmask_d = dst_ce_d ? mask_q : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      dst_base_q   <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      mask_q       <= '0;
      abort_flag_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      src_ce_q     <= 1'b0;
      src_addr_q   <= '0;
      dst_ce_q     <= 1'b0;
      dst_addr_q   <= '0;
      dst_wmask_q  <= '0;
      line_vld_q   <= '0;
      for (int i = 0; i < LineLen; i++) line_addr_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      dst_base_q   <= dst_base_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      mask_q       <= mask_d;
      abort_flag_q <= abort_flag_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      src_ce_q     <= src_ce_d;
      src_addr_q   <= src_addr_d;
      dst_ce_q     <= dst_ce_d;
      dst_addr_q   <= dst_addr_d;
      dst_wmask_q  <= dst_wmask_d;
      line_vld_q[0]  <= src_ce_q;
      line_addr_q[0] <= dst_base_q + cnt_q;
      for (int i = 1; i < LineLen; i++) begin
        line_vld_q[i]  <= line_vld_q[i-1];
        line_addr_q[i] <= line_addr_q[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign src_ce    = src_ce_q;
  assign src_we    = 1'b0;
  assign src_addr  = src_addr_q;
  assign dst_ce    = dst_ce_q;
  assign dst_we    = dst_ce_q;
  assign dst_addr  = dst_addr_q;
  assign dst_wmask = dst_wmask_q;

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Bench for mem_copy_ctrl: models both macros and the 3-stage pipeline, and scoreboards
// expected reads, writes and completions against the observed strobes.
module tb_mem_copy_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] src_base = '0;
  logic [5:0] dst_base = '0;
  logic [6:0] len = '0;
  logic [6:0] wmask = '0;
  logic       busy, done, aborted, src_ce, src_we, dst_ce, dst_we;
  logic [5:0] src_addr, dst_addr;
  logic [6:0] dst_wmask;

  mem_copy_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .len       (len),
    .wmask     (wmask),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .src_ce    (src_ce),
    .src_we    (src_we),
    .src_addr  (src_addr),
    .dst_ce    (dst_ce),
    .dst_we    (dst_we),
    .dst_addr  (dst_addr),
    .dst_wmask (dst_wmask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int addr;
    int aux;
  } ev_t;

  ev_t exp_rd[$];
  ev_t exp_wr[$];
  ev_t exp_dn[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic prev_done = 1'b0;
  logic clr_dst = 1'b0;

  logic [6:0] src_mem [64];
  logic [6:0] dst_mem [64];
  logic [6:0] exp_dst [64];
  logic [6:0] rd_out, p1, p2, p3;
  logic [25:0] outs;

  assign outs = {busy, done, aborted, src_ce, src_we, src_addr, dst_ce, dst_we, dst_addr,
                 dst_wmask};

  // Source macro (1-cycle read), 3-stage pipeline, destination macro with bit mask.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_ce && !src_we) rd_out <= src_mem[src_addr];
    p1 <= rd_out;
    p2 <= p1;
    p3 <= p2;
    if (clr_dst) begin
      for (int i = 0; i < 64; i++) dst_mem[i] <= '0;
    end else if (dst_ce && dst_we) begin
      dst_mem[dst_addr] <= (dst_mem[dst_addr] & ~dst_wmask) | (p3 & dst_wmask);
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (reset_n) begin
      if (src_ce) begin
        checks++;
        if (exp_rd.size() == 0) begin
          failures++;
          $display("FAIL src_read: unexpected read addr=%0d cycle=%0d, required none",
                   src_addr, cyc);
        end else begin
          e = exp_rd.pop_front();
          if (cyc !== e.cyc || src_addr !== 6'(e.addr) || src_we !== 1'b0) begin
            failures++;
            $display("FAIL src_read: got addr=%0d cycle=%0d we=%b, required addr=%0d cycle=%0d we=0",
                     src_addr, cyc, src_we, e.addr, e.cyc);
          end
        end
      end
      if (dst_ce) begin
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL dst_write: unexpected write addr=%0d cycle=%0d, required none",
                   dst_addr, cyc);
        end else begin
          e = exp_wr.pop_front();
          if (cyc !== e.cyc || dst_addr !== 6'(e.addr) || dst_we !== 1'b1 ||
              dst_wmask !== 7'(e.aux)) begin
            failures++;
            $display("FAIL dst_write: got addr=%0d cycle=%0d we=%b mask=%h, required addr=%0d cycle=%0d we=1 mask=%h",
                     dst_addr, cyc, dst_we, dst_wmask, e.addr, e.cyc, 7'(e.aux));
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_dn.size() == 0) begin
          failures++;
          $display("FAIL done: unexpected done at cycle=%0d, required none", cyc);
        end else begin
          e = exp_dn.pop_front();
          if (cyc !== e.cyc || aborted !== 1'(e.aux) || busy !== 1'b1) begin
            failures++;
            $display("FAIL done: got cycle=%0d aborted=%b busy=%b, required cycle=%0d aborted=%0d busy=1",
                     cyc, aborted, busy, e.cyc, e.aux);
          end
        end
      end
      if (prev_done) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_after_done: got busy=%b, required 0", busy);
        end
      end
    end
    prev_done <= done;
  end

  // Drives a start strobe at the next falling edge and queues everything it should cause.
  task automatic run_cmd(input int s, input int d, input int n, input int m, input int nrd,
                         input int ab, output int c0);
    @(negedge clk);
    src_base = 6'(s);
    dst_base = 6'(d);
    len      = 7'(n);
    wmask    = 7'(m);
    start    = 1'b1;
    c0       = cyc;
    for (int i = 0; i < nrd; i++) begin
      exp_rd.push_back('{c0 + 1 + i, (s + i) % 64, 0});
      exp_wr.push_back('{c0 + 5 + i, (d + i) % 64, m});
      exp_dst[(d + i) % 64] = (exp_dst[(d + i) % 64] & ~7'(m)) | (src_mem[(s + i) % 64] & 7'(m));
    end
    exp_dn.push_back('{(nrd == 0) ? c0 + 1 : c0 + nrd + 5, 0, ab});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic finish_check(input string name);
    int bad;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_rd.size() + exp_wr.size() + exp_dn.size() != 0) begin
      failures++;
      $display("FAIL %s_pending: got outstanding rd=%0d wr=%0d done=%0d, required 0", name,
               exp_rd.size(), exp_wr.size(), exp_dn.size());
      exp_rd.delete();
      exp_wr.delete();
      exp_dn.delete();
    end
    checks++;
    bad = -1;
    for (int i = 0; i < 64; i++) if (bad < 0 && dst_mem[i] !== exp_dst[i]) bad = i;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_data: dst[%0d] got %h, required %h", name, bad, dst_mem[bad],
               exp_dst[bad]);
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    clr_dst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    reset_n = 1'b1;
    clr_dst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL idle_outputs: got %h, required 0", outs);
    end
  endtask

  task automatic test_basic();
    int c0;
    run_cmd(0, 10, 4, 'h7F, 4, 0, c0);
    wait_until(c0 + 10);
    finish_check("basic");
  endtask

  task automatic test_wrap();
    int c0;
    run_cmd(62, 63, 3, 'h55, 3, 0, c0);
    wait_until(c0 + 9);
    finish_check("wrap");
  endtask

  task automatic test_zero_clamp();
    int c0;
    run_cmd(5, 20, 0, 'h7F, 0, 0, c0);
    wait_until(c0 + 3);
    finish_check("zero");
    run_cmd(0, 0, 100, 'h3C, 64, 0, c0);
    wait_until(c0 + 70);
    finish_check("clamp");
  endtask

  task automatic test_abort();
    int c0;
    run_cmd(8, 40, 20, 'h7F, 5, 1, c0);
    wait_until(c0 + 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_until(c0 + 11);
    finish_check("abort");
  endtask

  task automatic test_busy_start();
    int c0;
    run_cmd(16, 48, 8, 'h6B, 8, 0, c0);
    wait_until(c0 + 3);
    src_base = 6'd30;
    dst_base = 6'd2;
    len      = 7'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(c0 + 15);
    finish_check("busy_start");
  endtask

  task automatic test_back_to_back();
    int c0, c1;
    run_cmd(1, 3, 2, 'h7F, 2, 0, c0);
    wait_until(c0 + 7);
    run_cmd(33, 35, 3, 'h7F, 3, 0, c1);
    wait_until(c1 + 9);
    finish_check("back_to_back");
  endtask

  task automatic test_reset_mid();
    int c0, act;
    run_cmd(0, 20, 10, 'h7F, 10, 0, c0);
    wait_until(c0 + 6);
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h, required 0", outs);
    end
    exp_rd.delete();
    exp_wr.delete();
    exp_dn.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (src_ce || dst_ce || busy || done) act++;
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", act);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      src_mem[i] = 7'($urandom);
      exp_dst[i] = '0;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_zero_clamp();
    test_abort();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_copy_ctrl.md
# mem_copy_ctrl

Sequencer that copies a block of words from a source fakeram45_64x7 macro to a destination macro through an external fixed-depth register pipeline. The source read port feeds the pipeline, and the pipeline output drives the destination `wd_in`. The block issues source reads and drives destination address, chip-enable, write-enable and write mask so each write coincides with its word leaving the pipeline. It sits beside the memory macros and is started by a single-cycle command from the host logic.

## Interface
- `ADDR_W`, 6: macro address width (64 words).
- `DATA_W`, 7: macro data and mask width.
- `RD_LAT`, 1: source macro read latency, in cycles.
- `PIPE_DEPTH`, 3: number of register stages between source `rd_out` and destination `wd_in`.

- `clk`  in  1  single clock for the block and both macros.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `src_base`  in  ADDR_W  first source address.
- `dst_base`  in  ADDR_W  first destination address.
- `len`  in  ADDR_W+1  word count; 0 is a no-op, 65..127 are clamped to 64.
- `wmask`  in  DATA_W  write mask applied to every destination write.
- `abort`  in  1  stop issuing source reads; in-flight words still complete.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  valid with `done`; high if the command was cut short by `abort`.
- `src_ce`  out  1  source chip enable.
- `src_we`  out  1  source write enable; always 0.
- `src_addr`  out  ADDR_W  source address.
- `dst_ce`  out  1  destination chip enable.
- `dst_we`  out  1  destination write enable.
- `dst_addr`  out  ADDR_W  destination address.
- `dst_wmask`  out  DATA_W  destination write mask.

## Operation
- The state machine has four states: IDLE, READ, DRAIN, DONE.
- **IDLE**
  - On `start`, latch `src_base`, `dst_base`, the clamped `len` and `wmask`, and clear the internal abort flag.
  - If the clamped `len` is 0, go to DONE; otherwise go to READ.
  - `start` outside IDLE is ignored.
- **READ**
  - One source read per cycle: `src_ce`=1, `src_addr` = src_base + i (mod 64), for i = 0 .. len-1.
  - After the read with i = len-1, go to DRAIN.
  - If `abort` is sampled high, issue no further reads, set the abort flag and go to DRAIN.
- **Delay line**
  - Depth is D = RD_LAT + PIPE_DEPTH.
  - Each issued read pushes {valid, dst_base + i mod 64} into the line; idle cycles push an invalid entry.
  - While the line output is valid: `dst_ce`=1, `dst_we`=1, `dst_addr` = entry address, `dst_wmask` = latched mask. Otherwise all three strobes are 0.
- **DRAIN**: wait until the delay line holds no valid entry, then go to DONE. `abort` is ignored here.
- **DONE**: `done`=1 for one cycle, `aborted` = abort flag, then go to IDLE.
- **Address arithmetic**: ADDR_W-bit modulo, so addresses wrap from 63 to 0.
- **Outputs**: all outputs are registered.
- **Reset**
  - Asynchronous assertion returns the block to IDLE and clears the delay line immediately.
  - Reset values: all outputs 0, including `busy`, `done`, `aborted`, every ce/we strobe, both addresses and `dst_wmask`.
  - A copy interrupted by reset is abandoned; no write is issued after `reset_n` deasserts.

## Timing
- `start` sampled at edge E0 → `busy`=1 and the first `src_ce` appear in cycle C1.
- The read issued in Ck produces its destination write in C(k+D); with defaults, D = 4.
- Full copy of N words:
  - source reads in C1..CN;
  - destination writes in C5..C(N+4);
  - `done` in C(N+5).
- `busy` is high from C1 through the `done` cycle inclusive and low in the following cycle.
- A new `start` is accepted in the cycle after `done`.
- `len`=0: `busy` and `done` are both high in C1, with no ce activity.
- `abort` sampled at the edge ending cycle Cj of READ: the read in Cj still completes, the last write lands in C(j+4), and `done` with `aborted`=1 follows in C(j+5).

## Test plan
- **Basic copy**
  - Stimulus: src_base=0, dst_base=10, len=4, wmask=7'h7F.
  - Required: source reads of addresses 0..3 in C1..C4; destination writes to 10..13 in C5..C8; `done` in C9; destination contents equal source contents.
- **Wrap**
  - Stimulus: src_base=62, dst_base=63, len=3.
  - Required: source addresses 62, 63, 0; destination addresses 63, 0, 1.
- **Zero and clamp**
  - Stimulus: len=0; then len=100.
  - Required: for len=0, `done` in C1 with no ce activity; for len=100, exactly 64 writes and `done` in C69.
- **Abort**
  - Stimulus: len=20, `abort` high in C5.
  - Required: 5 reads and 5 writes (last write in C9); `done` with `aborted`=1 in C10.
- **Busy start**
  - Stimulus: `start` pulsed again in C3 of a len=8 copy.
  - Required: ignored, no base change; single `done` in C13.
- **Reset mid-operation**
  - Stimulus: `reset_n` low in C6 of a len=10 copy.
  - Required: all outputs 0 immediately; after release, no ce activity until the next `start`.
